// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencing controller:
// command codes, operator enum, FSM state constants and status codes.
package calc_pkg;

    localparam logic [3:0] CMD_ADD   = 4'hA;
    localparam logic [3:0] CMD_SUB   = 4'hB;
    localparam logic [3:0] CMD_MUL   = 4'hC;
    localparam logic [3:0] CMD_CLEAR = 4'hD;
    localparam logic [3:0] CMD_EQ    = 4'hE;
    localparam logic [3:0] CMD_DIV   = 4'hF;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_DIV
    } op_t;

    typedef logic [2:0] state_t;

    localparam state_t S_ENTER_A = 3'd0;
    localparam state_t S_ENTER_B = 3'd1;
    localparam state_t S_CALC    = 3'd2;
    localparam state_t S_MUL_RUN = 3'd3;
    localparam state_t S_RESULT  = 3'd4;
    localparam state_t S_ERROR   = 3'd5;
    localparam state_t S_DIV_RUN = 3'd6;

    localparam logic [1:0] STAT_READY = 2'b00;
    localparam logic [1:0] STAT_BUSY  = 2'b01;
    localparam logic [1:0] STAT_ERR   = 2'b10;

    function automatic op_t cmd_to_op(input logic [3:0] c);
        op_t o;
        case (c)
            CMD_SUB: o = OP_SUB;
            CMD_MUL: o = OP_MUL;
            CMD_DIV: o = OP_DIV;
            default: o = OP_ADD;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/calc_div_seq.sv
// Restoring divider, WIDTH-cycle latency; quotient only (truncated).
// Ports: clk_i, flush_i, start_i, a_i (dividend), b_i -> done_o, quo_o.
module calc_div_seq #(
    parameter int WIDTH = 27
) (
    input  logic             clk_i,
    input  logic             flush_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quo_o
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q;
    logic [WIDTH-1:0] rem_in, quo_in, dvs_in, rem_nx, quo_nx;
    logic [WIDTH:0]   trial;
    logic             qbit;

    // One restoring step; the start edge performs the first one
    // directly on the incoming operands.
    always_comb begin
        rem_in = start_i ? '0  : rem_q;
        quo_in = start_i ? a_i : quo_q;
        dvs_in = start_i ? b_i : dvs_q;
        trial  = {rem_in, quo_in[WIDTH-1]};
        qbit   = trial >= {1'b0, dvs_in};
        if (qbit) trial = trial - {1'b0, dvs_in};
        rem_nx = trial[WIDTH-1:0];
        quo_nx = {quo_in[WIDTH-2:0], qbit};
    end

    always_ff @(posedge clk_i) begin
        if (flush_i) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            dvs_q <= b_i;
            cnt_q <= CW'(WIDTH - 1);
            run_q <= 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end else begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign done_o = run_q && (cnt_q == '0);
    assign quo_o  = quo_q;

endmodule

// File: rtl/calc_mul_seq.sv
// Shift-add multiplier, WIDTH-cycle latency, 2*WIDTH-bit product.
// Ports: clk_i, flush_i (abort), start_i, a_i, b_i -> done_o, prod_o.
module calc_mul_seq #(
    parameter int WIDTH = 27
) (
    input  logic               clk_i,
    input  logic               flush_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    mc_q;
    logic [WIDTH-1:0] mp_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q;

    // The start edge already consumes multiplier bit 0, so the
    // remaining WIDTH-1 bits finish exactly WIDTH edges after start.
    always_ff @(posedge clk_i) begin
        if (flush_i) begin
            acc_q <= '0;
            mc_q  <= '0;
            mp_q  <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            acc_q <= a_i[0] ? PW'(b_i) : '0;
            mc_q  <= PW'(b_i) << 1;
            mp_q  <= a_i >> 1;
            cnt_q <= CW'(WIDTH - 1);
            run_q <= 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end else begin
                if (mp_q[0]) acc_q <= acc_q + mc_q;
                mc_q  <= mc_q << 1;
                mp_q  <= mp_q >> 1;
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign done_o = run_q && (cnt_q == '0);
    assign prod_o = acc_q;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencing controller: digit entry, add/sub/mul(/div), display.
// Ports: clock, reset, cmd, cmd_valid -> value, neg, status. Macro CALC_DIV_EN adds DIV.
import calc_pkg::*;

module calc_seq_ctrl #(
    parameter int DIGITS = 8,
    parameter int WIDTH  = 27
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       cmd,
    input  logic             cmd_valid,
    output logic [WIDTH-1:0] value,
    output logic             neg,
    output logic [1:0]       status
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam int PW = 2 * WIDTH;
    localparam logic [PW-1:0] MAXV = PW'(10 ** DIGITS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    op_t              op_q, op_d, pend_q, pend_d;
    logic             chain_q, chain_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] disp_q, disp_d;
    logic             neg_q, neg_d;

    logic             is_digit, is_op, is_clear, is_eq, busy, flush;
    logic             fin, go_err, res_neg;
    logic [PW-1:0]    res_mag;
    logic [WIDTH-1:0] res_clip;
    logic             mul_start, mul_done;
    logic [PW-1:0]    mul_prod;

    function automatic logic [WIDTH-1:0] shift_in(
        input logic [WIDTH-1:0] v,
        input logic [3:0]       d
    );
        logic [WIDTH+3:0] t;
        t = {4'b0, v} * (WIDTH + 4)'(10) + (WIDTH + 4)'(d);
        return t[WIDTH-1:0];
    endfunction

    assign is_digit = cmd <= 4'd9;
    assign is_clear = cmd == CMD_CLEAR;
    assign is_eq    = cmd == CMD_EQ;
`ifdef CALC_DIV_EN
    assign is_op = (cmd == CMD_ADD) || (cmd == CMD_SUB)
                || (cmd == CMD_MUL) || (cmd == CMD_DIV);
`else
    assign is_op = (cmd == CMD_ADD) || (cmd == CMD_SUB)
                || (cmd == CMD_MUL);
`endif
    assign busy  = (state_q == S_CALC) || (state_q == S_MUL_RUN)
                || (state_q == S_DIV_RUN);
    // Clear aborts an engine run on the same edge it resets the FSM.
    assign flush = reset || (cmd_valid && is_clear);

    calc_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk_i   (clock),
        .flush_i (flush),
        .start_i (mul_start),
        .a_i     (opa_q),
        .b_i     (opb_q),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

`ifdef CALC_DIV_EN
    logic             div_start, div_done;
    logic [WIDTH-1:0] div_quo;

    calc_div_seq #(.WIDTH(WIDTH)) u_div (
        .clk_i   (clock),
        .flush_i (flush),
        .start_i (div_start),
        .a_i     (opa_q),
        .b_i     (opb_q),
        .done_o  (div_done),
        .quo_o   (div_quo)
    );
`endif

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        op_d      = op_q;
        pend_d    = pend_q;
        chain_d   = chain_q;
        cnt_d     = cnt_q;
        disp_d    = disp_q;
        neg_d     = neg_q;
        mul_start = 1'b0;
`ifdef CALC_DIV_EN
        div_start = 1'b0;
`endif
        fin       = 1'b0;
        go_err    = 1'b0;
        res_mag   = '0;
        res_neg   = 1'b0;

        // Engine progress runs regardless of cmd_valid.
        case (state_q)
            S_CALC: begin
                case (op_q)
                    OP_ADD: begin
                        fin     = 1'b1;
                        res_mag = PW'(opa_q) + PW'(opb_q);
                    end
                    OP_SUB: begin
                        fin     = 1'b1;
                        res_neg = opb_q > opa_q;
                        res_mag = res_neg ? PW'(opb_q - opa_q)
                                          : PW'(opa_q - opb_q);
                    end
                    OP_MUL: begin
                        mul_start = 1'b1;
                        state_d   = S_MUL_RUN;
                    end
                    default: begin
`ifdef CALC_DIV_EN
                        if (opb_q == '0) begin
                            go_err = 1'b1;
                        end else begin
                            div_start = 1'b1;
                            state_d   = S_DIV_RUN;
                        end
`else
                        go_err = 1'b1;
`endif
                    end
                endcase
            end
            S_MUL_RUN: begin
                if (mul_done) begin
                    fin     = 1'b1;
                    res_mag = mul_prod;
                end
            end
`ifdef CALC_DIV_EN
            S_DIV_RUN: begin
                if (div_done) begin
                    fin     = 1'b1;
                    res_mag = PW'(div_quo);
                end
            end
`endif
            default: ;
        endcase

        // A negative result carried forward as an operand counts as 0.
        res_clip = res_neg ? '0 : res_mag[WIDTH-1:0];

        if (fin && (res_mag > MAXV)) begin
            go_err = 1'b1;
        end else if (fin && chain_q) begin
            opa_d   = res_clip;
            opb_d   = '0;
            cnt_d   = '0;
            op_d    = pend_q;
            chain_d = 1'b0;
            disp_d  = res_clip;
            neg_d   = 1'b0;
            state_d = S_ENTER_B;
        end else if (fin) begin
            disp_d  = res_mag[WIDTH-1:0];
            neg_d   = res_neg;
            state_d = S_RESULT;
        end

        if (go_err) begin
            disp_d  = '0;
            neg_d   = 1'b0;
            chain_d = 1'b0;
            state_d = S_ERROR;
        end

        if (cmd_valid && !busy) begin
            case (state_q)
                S_ENTER_A: begin
                    if (is_digit && (cnt_q < CW'(DIGITS))) begin
                        opa_d  = shift_in(opa_q, cmd);
                        disp_d = shift_in(opa_q, cmd);
                        cnt_d  = cnt_q + CW'(1);
                        neg_d  = 1'b0;
                    end else if (is_op) begin
                        op_d    = cmd_to_op(cmd);
                        opb_d   = '0;
                        cnt_d   = '0;
                        state_d = S_ENTER_B;
                    end
                end
                S_ENTER_B: begin
                    if (is_digit && (cnt_q < CW'(DIGITS))) begin
                        opb_d  = shift_in(opb_q, cmd);
                        disp_d = shift_in(opb_q, cmd);
                        cnt_d  = cnt_q + CW'(1);
                        neg_d  = 1'b0;
                    end else if (is_op) begin
                        pend_d  = cmd_to_op(cmd);
                        chain_d = 1'b1;
                        state_d = S_CALC;
                    end else if (is_eq) begin
                        state_d = S_CALC;
                    end
                end
                S_RESULT: begin
                    if (is_digit) begin
                        opa_d   = WIDTH'(cmd);
                        opb_d   = '0;
                        op_d    = OP_ADD;
                        cnt_d   = CW'(1);
                        disp_d  = WIDTH'(cmd);
                        neg_d   = 1'b0;
                        state_d = S_ENTER_A;
                    end else if (is_op) begin
                        opa_d   = neg_q ? '0 : disp_q;
                        disp_d  = neg_q ? '0 : disp_q;
                        neg_d   = 1'b0;
                        opb_d   = '0;
                        cnt_d   = '0;
                        op_d    = cmd_to_op(cmd);
                        state_d = S_ENTER_B;
                    end
                end
                default: ;
            endcase
        end

        if (cmd_valid && is_clear) begin
            state_d = S_ENTER_A;
            opa_d   = '0;
            opb_d   = '0;
            op_d    = OP_ADD;
            pend_d  = OP_ADD;
            chain_d = 1'b0;
            cnt_d   = '0;
            disp_d  = '0;
            neg_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_ENTER_A;
            opa_q   <= '0;
            opb_q   <= '0;
            op_q    <= OP_ADD;
            pend_q  <= OP_ADD;
            chain_q <= 1'b0;
            cnt_q   <= '0;
            disp_q  <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            pend_q  <= pend_d;
            chain_q <= chain_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            neg_q   <= neg_d;
        end
    end

    assign value  = disp_q;
    assign neg    = neg_q;
    assign status = (state_q == S_ERROR) ? STAT_ERR
                  : busy                 ? STAT_BUSY
                  :                        STAT_READY;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl: directed scenarios plus
// random key sequences against an arithmetic calculator model.
module tb_calc_seq_ctrl;

    localparam int W = 27;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   cmd;
    logic         cmd_valid;
    logic [W-1:0] value;
    logic         neg;
    logic [1:0]   status;

    int errs = 0;
    int checks = 0;

    calc_seq_ctrl #(.DIGITS(8), .WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .value     (value),
        .neg       (neg),
        .status    (status)
    );

    always #5 clock = ~clock;

    // Calculator model: mode 0 entering A, 1 entering B, 2 result, 3 error
    int     m_mode;
    longint m_a, m_b, m_disp;
    bit     m_neg;
    int     m_op;
    int     m_cnt;

    function automatic void m_reset();
        m_mode = 0; m_a = 0; m_b = 0; m_disp = 0;
        m_neg = 0; m_op = 10; m_cnt = 0;
    endfunction

    function automatic bit m_is_op(input int c);
`ifdef CALC_DIV_EN
        return (c >= 10 && c <= 12) || c == 15;
`else
        return c >= 10 && c <= 12;
`endif
    endfunction

    function automatic void m_eval(output bit err, output longint mag,
                                   output bit n);
        longint d;
        err = 0; n = 0; mag = 0;
        case (m_op)
            10: mag = m_a + m_b;
            11: begin
                d = m_a - m_b;
                n = d < 0;
                mag = n ? -d : d;
            end
            12: mag = m_a * m_b;
            default: begin
                if (m_b == 0) err = 1;
                else mag = m_a / m_b;
            end
        endcase
        if (mag > 64'd99999999) err = 1;
    endfunction

    function automatic void m_apply(input int c);
        bit err, n;
        longint mag;
        if (c == 13) begin
            m_reset();
            return;
        end
        if (m_mode == 3) return;
        if (c <= 9) begin
            if (m_mode == 2) begin
                m_a = c; m_b = 0; m_cnt = 1; m_disp = c;
                m_neg = 0; m_mode = 0;
            end else if (m_cnt < 8) begin
                if (m_mode == 0) begin
                    m_a = m_a * 10 + c; m_disp = m_a;
                end else begin
                    m_b = m_b * 10 + c; m_disp = m_b;
                end
                m_cnt++;
                m_neg = 0;
            end
        end else if (m_is_op(c)) begin
            if (m_mode == 1) begin
                m_eval(err, mag, n);
                if (err) begin
                    m_mode = 3; m_disp = 0; m_neg = 0;
                    return;
                end
                m_a = n ? 0 : mag;
            end else if (m_mode == 2) begin
                m_a = m_neg ? 0 : m_disp;
            end
            m_disp = m_a; m_neg = 0; m_b = 0;
            m_cnt = 0; m_op = c; m_mode = 1;
        end else if (c == 14 && m_mode == 1) begin
            m_eval(err, mag, n);
            if (err) begin
                m_mode = 3; m_disp = 0; m_neg = 0;
            end else begin
                m_mode = 2; m_disp = mag; m_neg = n;
            end
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Strobe for one cycle; returns 1 time unit after the sampling edge.
    task automatic send(input logic [3:0] c);
        cmd = c;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic key(input logic [3:0] c);
        send(c);
        idle(9);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd = 4'd0;
        cmd_valid = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(1);
        checks++;
        if (value !== '0) begin
            errs++; $display("FAIL reset_value: got %0d want 0", value);
        end
        checks++;
        if (neg !== 1'b0) begin
            errs++; $display("FAIL reset_neg: got %0b want 0", neg);
        end
        checks++;
        if (status !== 2'b00) begin
            errs++; $display("FAIL reset_status: got %0b want 00", status);
        end
    endtask

    task automatic test_add();
        key(4'd1);
        key(4'd2);
        checks++;
        if (value !== 27'd12) begin
            errs++; $display("FAIL add_key12: got %0d want 12", value);
        end
        key(4'hA);
        key(4'd3);
        checks++;
        if (value !== 27'd3) begin
            errs++; $display("FAIL add_key3: got %0d want 3", value);
        end
        send(4'hE);
        checks++;
        if (status !== 2'b01) begin
            errs++; $display("FAIL add_calc_busy: got %0b want 01", status);
        end
        idle(1);
        checks++;
        if (value !== 27'd15 || status !== 2'b00) begin
            errs++;
            $display("FAIL add_result: got %0d/%0b want 15/00",
                     value, status);
        end
        idle(8);
    endtask

    task automatic test_sub_neg();
        key(4'hD);
        key(4'd5);
        key(4'hB);
        key(4'd9);
        send(4'hE);
        idle(1);
        checks++;
        if (value !== 27'd4 || neg !== 1'b1) begin
            errs++;
            $display("FAIL sub_neg: got %0d neg=%0b want 4 neg=1",
                     value, neg);
        end
        idle(8);
        key(4'hC);
        key(4'd2);
        send(4'hE);
        idle(W + 1);
        checks++;
        if (value !== '0 || neg !== 1'b0 || status !== 2'b00) begin
            errs++;
            $display("FAIL neg_as_zero: got %0d neg=%0b st=%0b want 0/0/00",
                     value, neg, status);
        end
        idle(5);
    endtask

    task automatic test_mul_busy();
        int n;
        key(4'hD);
        key(4'd1);
        key(4'd2);
        key(4'hC);
        key(4'd3);
        send(4'hE);
        n = 0;
        while (status === 2'b01 && n < 100) begin
            n++;
            if (n == 5) begin
                cmd = 4'd7;
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            @(posedge clock);
            #1;
        end
        cmd_valid = 1'b0;
        checks++;
        if (n != W + 1) begin
            errs++; $display("FAIL mul_busy_len: got %0d want %0d", n, W + 1);
        end
        checks++;
        if (value !== 27'd36 || neg !== 1'b0 || status !== 2'b00) begin
            errs++;
            $display("FAIL mul_result: got %0d/%0b/%0b want 36/0/00",
                     value, neg, status);
        end
        idle(5);
    endtask

    task automatic test_overflow();
        key(4'hD);
        repeat (9) key(4'd9);
        checks++;
        if (value !== 27'd99999999) begin
            errs++; $display("FAIL digit_limit: got %0d want 99999999", value);
        end
        key(4'hA);
        key(4'd1);
        send(4'hE);
        idle(1);
        checks++;
        if (status !== 2'b10 || value !== '0) begin
            errs++;
            $display("FAIL overflow: got %0d/%0b want 0/10", value, status);
        end
        idle(5);
        key(4'd4);
        checks++;
        if (status !== 2'b10 || value !== '0) begin
            errs++;
            $display("FAIL err_ignore: got %0d/%0b want 0/10", value, status);
        end
        send(4'hD);
        checks++;
        if (status !== 2'b00 || value !== '0) begin
            errs++;
            $display("FAIL err_clear: got %0d/%0b want 0/00", value, status);
        end
        idle(5);
    endtask

    task automatic test_chain();
        key(4'hD);
        key(4'd2);
        key(4'hA);
        key(4'd3);
        send(4'hA);
        idle(1);
        checks++;
        if (value !== 27'd5 || status !== 2'b00) begin
            errs++;
            $display("FAIL chain_mid: got %0d/%0b want 5/00", value, status);
        end
        idle(8);
        key(4'd4);
        send(4'hE);
        idle(1);
        checks++;
        if (value !== 27'd9) begin
            errs++; $display("FAIL chain_end: got %0d want 9", value);
        end
        idle(5);
    endtask

    task automatic test_eq_noop();
        key(4'hD);
        key(4'd4);
        send(4'hE);
        idle(2);
        checks++;
        if (value !== 27'd4 || status !== 2'b00) begin
            errs++;
            $display("FAIL eq_in_a: got %0d/%0b want 4/00", value, status);
        end
        idle(5);
    endtask

    task automatic test_clear_busy();
        key(4'hD);
        key(4'd3);
        key(4'hC);
        key(4'd4);
        send(4'hE);
        idle(5);
        send(4'hD);
        checks++;
        if (value !== '0 || status !== 2'b00) begin
            errs++;
            $display("FAIL clear_busy: got %0d/%0b want 0/00", value, status);
        end
        idle(W + 3);
        checks++;
        if (value !== '0 || status !== 2'b00) begin
            errs++;
            $display("FAIL clear_abort: got %0d/%0b want 0/00", value, status);
        end
    endtask

    task automatic test_reset_mid_mul();
        key(4'hD);
        key(4'd7);
        key(4'hC);
        key(4'd8);
        send(4'hE);
        idle(10);
        reset = 1'b1;
        idle(1);
        checks++;
        if (value !== '0 || status !== 2'b00 || neg !== 1'b0) begin
            errs++;
            $display("FAIL reset_mid_mul: got %0d/%0b want 0/00",
                     value, status);
        end
        reset = 1'b0;
        idle(W + 5);
        checks++;
        if (value !== '0 || status !== 2'b00) begin
            errs++;
            $display("FAIL mul_aborted: got %0d/%0b want 0/00", value, status);
        end
        key(4'd6);
        checks++;
        if (value !== 27'd6) begin
            errs++; $display("FAIL entry_after_rst: got %0d want 6", value);
        end
    endtask

    task automatic test_random();
        int r;
        logic [3:0] c;
        m_reset();
        key(4'hD);
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55) c = 4'($urandom_range(0, 9));
            else if (r < 60) c = 4'hD;
            else c = 4'($urandom_range(10, 15));
            send(c);
            m_apply(int'(c));
            idle(W + 5);
            checks++;
            if (value !== W'(m_disp) || neg !== m_neg
                || status !== ((m_mode == 3) ? 2'b10 : 2'b00)) begin
                errs++;
                $display("FAIL rand_%0d cmd=%0d: got %0d/%0b/%0b want %0d/%0b/%0b",
                         i, c, value, neg, status, m_disp, m_neg,
                         (m_mode == 3) ? 2'b10 : 2'b00);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_neg();
        test_mul_busy();
        test_overflow();
        test_chain();
        test_eq_noop();
        test_clear_busy();
        test_reset_mid_mul();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
